// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: stall/flush of IF/ID and ID/EX, EX operand forwarding, redirect and FENCE sequencing.
// Latency: all controls are combinational from current state and inputs; state advances on posedge clk_in.
// Backpressure: a load-use stalls one cycle; FENCE holds the front end until the drain count expires and mem_busy drops.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush performance counters (tied to 0 otherwise).
module hazard_ctrl #(
    parameter int unsigned REDIRECT_FLUSH_CYC = 1,
    parameter int unsigned DRAIN_CYCLES       = 2,
    parameter logic [1:0]  WB_SEL_MEM         = 2'b01
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [4:0]  rs1addr_d,
    input  logic [4:0]  rs2addr_d,
    input  logic [4:0]  rs1addr_e,
    input  logic [4:0]  rs2addr_e,
    input  logic [4:0]  rd_e,
    input  logic        regwe_e,
    input  logic [1:0]  wb_sel_e,
    input  logic        fence_e,
    input  logic        redirect_e,
    input  logic [4:0]  rd_m,
    input  logic        regwe_m,
    input  logic [4:0]  rd_w,
    input  logic        regwe_w,
    input  logic        mem_busy,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        fence_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_FENCE = 2'd2
    } state_t;

    // Reload value leaves REDIR after the redirect cycle plus (REDIRECT_FLUSH_CYC-1) more cycles.
    localparam logic [2:0] RCNT_RELOAD = 3'(REDIRECT_FLUSH_CYC - 1);
    localparam logic [3:0] DCNT_LOAD   = 4'(DRAIN_CYCLES);

    state_t     state_q, state_d;
    logic [2:0] rcnt_q, rcnt_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic       luse;

    // Select the youngest producer of a source register; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (regwe_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b01;
        end else if (regwe_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // Forwarding selects, forced to the register file while in reset.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (!rst_in) begin
            fwd_a_sel = fwd_sel(rs1addr_e);
            fwd_b_sel = fwd_sel(rs2addr_e);
        end
    end

    // A load in execute whose result is needed by the instruction in decode.
    assign luse = regwe_e && (wb_sel_e == WB_SEL_MEM) && (rd_e != 5'd0) &&
                  ((rd_e == rs1addr_d) || (rd_e == rs2addr_d));

    // Next-state and control outputs; redirect outranks load-use and FENCE entry.
    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        dcnt_d     = dcnt_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        fence_busy = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect_e) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    if (REDIRECT_FLUSH_CYC > 1) begin
                        state_d = ST_REDIR;
                        rcnt_d  = RCNT_RELOAD;
                    end
                end else begin
                    if (luse) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                    if (fence_e) begin
                        state_d = ST_FENCE;
                        dcnt_d  = DCNT_LOAD;
                    end
                end
            end
            ST_REDIR: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (redirect_e) begin
                    rcnt_d = RCNT_RELOAD;
                end else if (rcnt_q <= 3'd1) begin
                    rcnt_d  = 3'd0;
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q - 3'd1;
                end
            end
            ST_FENCE: begin
                // Redirects are ignored here: the front end is stalled and execute holds bubbles.
                stall_f    = 1'b1;
                stall_d    = 1'b1;
                flush_e    = 1'b1;
                fence_busy = 1'b1;
                if (dcnt_q != 4'd0) begin
                    dcnt_d = dcnt_q - 4'd1;
                end else if (!mem_busy) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (rst_in) begin
            stall_f    = 1'b0;
            stall_d    = 1'b0;
            flush_d    = 1'b1;
            flush_e    = 1'b1;
            fence_busy = 1'b0;
        end
    end

    // State and sequencing counters; reset drops any pending redirect or FENCE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_RUN;
            rcnt_q  <= 3'd0;
            dcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Wrapping event counts; reset-forced flushes are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_f};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_e & ~rst_in};
    end

    // Counter registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl built with a 3-cycle redirect flush and a 2-cycle FENCE drain.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Ends with a single summary line.
module tb_hazard_ctrl;

    localparam int R = 3;
    localparam int D = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [4:0]  rs1addr_d, rs2addr_d, rs1addr_e, rs2addr_e, rd_e, rd_m, rd_w;
    logic        regwe_e, regwe_m, regwe_w, fence_e, redirect_e, mem_busy;
    logic [1:0]  wb_sel_e;
    logic        stall_f, stall_d, flush_d, flush_e, fence_busy;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(
        .REDIRECT_FLUSH_CYC(R),
        .DRAIN_CYCLES      (D),
        .WB_SEL_MEM        (2'b01)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rs1addr_d (rs1addr_d),
        .rs2addr_d (rs2addr_d),
        .rs1addr_e (rs1addr_e),
        .rs2addr_e (rs2addr_e),
        .rd_e      (rd_e),
        .regwe_e   (regwe_e),
        .wb_sel_e  (wb_sel_e),
        .fence_e   (fence_e),
        .redirect_e(redirect_e),
        .rd_m      (rd_m),
        .regwe_m   (regwe_m),
        .rd_w      (rd_w),
        .regwe_w   (regwe_w),
        .mem_busy  (mem_busy),
        .stall_f   (stall_f),
        .stall_d   (stall_d),
        .flush_d   (flush_d),
        .flush_e   (flush_e),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel),
        .fence_busy(fence_busy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        rs1addr_d = 0; rs2addr_d = 0; rs1addr_e = 0; rs2addr_e = 0;
        rd_e = 0; regwe_e = 0; wb_sel_e = 0; fence_e = 0; redirect_e = 0;
        rd_m = 0; regwe_m = 0; rd_w = 0; regwe_w = 0; mem_busy = 0;
    endtask

    task automatic set_luse(input logic on);
        regwe_e   = on;
        wb_sel_e  = 2'b01;
        rd_e      = on ? 5'd5 : 5'd0;
        rs1addr_d = 5'd5;
    endtask

    // Next input phase: 1 unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_in = 1'b1;
        next_cycle();
        next_cycle();
        rst_in = 1'b0;
    endtask

    // {stall_f, stall_d, flush_d, flush_e, fence_busy}
    function automatic logic [4:0] ctl();
        return {stall_f, stall_d, flush_d, flush_e, fence_busy};
    endfunction

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       rwe_e;
        logic [1:0] wbs;
        logic [4:0] rdm;
        logic       rwe_m;
        logic [4:0] rdw;
        logic       rwe_w;
        logic       exp_stall;
        logic [1:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs[13];

    // Reference model state: forced-flush cycles still owed, FENCE occupancy.
    int  m_redir_left;
    bit  m_in_fence;
    int  m_fence_age;
    longint m_stall_n, m_flush_n;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regwe_m && rd_m != 0 && rd_m == rs) return 2'b01;
        if (regwe_w && rd_w != 0 && rd_w == rs) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        logic [4:0] exp_ctl;
        logic       m_luse;
        logic [31:0] exp_sc, exp_fc;

        // Reset held with inputs that would otherwise forward and load-use stall.
        set_idle();
        rst_in    = 1'b1;
        rs1addr_e = 5'd3; rd_m = 5'd3; regwe_m = 1'b1;
        set_luse(1'b1);
        #2;
        chk("reset_ctl", 64'(ctl()), 64'(5'b00110));
        chk("reset_fwd", 64'({fwd_a_sel, fwd_b_sel}), 64'd0);
        chk("reset_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
        next_cycle();
        rst_in = 1'b0;
        set_idle();
        @(negedge clk_in);
        chk("post_reset_ctl", 64'(ctl()), 64'd0);

        // Combinational load-use and forwarding vectors, all in RUN.
        vecs[0]  = '{5, 0, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00};
        vecs[1]  = '{5, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[2]  = '{0, 5, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00};
        vecs[3]  = '{5, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[4]  = '{5, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[5]  = '{0, 0, 3, 0, 0, 0, 2'b00, 3, 1, 3, 1, 0, 2'b01, 2'b00};
        vecs[6]  = '{0, 0, 3, 0, 0, 0, 2'b00, 3, 0, 3, 1, 0, 2'b10, 2'b00};
        vecs[7]  = '{0, 0, 3, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00};
        vecs[9]  = '{0, 0, 3, 7, 0, 0, 2'b00, 3, 1, 7, 1, 0, 2'b01, 2'b10};
        vecs[10] = '{0, 0, 4, 4, 0, 0, 2'b00, 4, 1, 9, 1, 0, 2'b01, 2'b01};
        vecs[11] = '{9, 9, 0, 9, 9, 1, 2'b01, 9, 0, 9, 1, 1, 2'b00, 2'b10};
        vecs[12] = '{5, 0, 0, 0, 5, 1, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            set_idle();
            rs1addr_d = vecs[i].rs1d; rs2addr_d = vecs[i].rs2d;
            rs1addr_e = vecs[i].rs1e; rs2addr_e = vecs[i].rs2e;
            rd_e = vecs[i].rde; regwe_e = vecs[i].rwe_e; wb_sel_e = vecs[i].wbs;
            rd_m = vecs[i].rdm; regwe_m = vecs[i].rwe_m;
            rd_w = vecs[i].rdw; regwe_w = vecs[i].rwe_w;
            @(negedge clk_in);
            chk($sformatf("vec%0d", i),
                64'({stall_f, stall_d, flush_e, flush_d, fwd_a_sel, fwd_b_sel}),
                64'({vecs[i].exp_stall, vecs[i].exp_stall, vecs[i].exp_stall, 1'b0,
                     vecs[i].exp_a, vecs[i].exp_b}));
        end

        // Redirect with a simultaneous load-use: 3 flush cycles and no stall.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            set_luse(i < 3);
            redirect_e = (i == 0);
            @(negedge clk_in);
            chk($sformatf("redirect_c%0d", i), 64'(ctl()),
                64'((i < 3) ? 5'b00110 : 5'b00000));
            next_cycle();
        end

        // FENCE: mem_busy high for the first 4 FENCE cycles, a redirect is ignored inside.
        set_idle();
        fence_e  = 1'b1;
        mem_busy = 1'b1;
        @(negedge clk_in);
        chk("fence_entry", 64'(ctl()), 64'd0);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            set_idle();
            mem_busy   = (i < 4);
            redirect_e = (i == 1);
            @(negedge clk_in);
            chk($sformatf("fence_c%0d", i), 64'(ctl()),
                64'((i < 5) ? 5'b11011 : 5'b00000));
        end

        // Async reset between edges in the middle of a FENCE.
        next_cycle();
        set_idle();
        fence_e  = 1'b1;
        mem_busy = 1'b1;
        next_cycle();
        fence_e = 1'b0;
        next_cycle();
        @(negedge clk_in);
        chk("fence_before_rst", 64'(ctl()), 64'(5'b11011));
        #2;
        rst_in = 1'b1;
        #1;
        chk("rst_mid_fence", 64'(ctl()), 64'(5'b00110));
        next_cycle();
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("after_rst_release", 64'(ctl()), 64'd0);

        // Performance counters: one load-use, then a 3-cycle FENCE.
        do_reset();
        set_luse(1'b1);
        next_cycle();
        set_idle();
        fence_e = 1'b1;
        next_cycle();
        set_idle();
        for (int i = 0; i < 4; i++) next_cycle();
        @(negedge clk_in);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_cnt", 64'(stall_cnt), 64'd4);
        chk("perf_flush_cnt", 64'(flush_cnt), 64'd4);
`else
        chk("perf_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("perf_flush_cnt", 64'(flush_cnt), 64'd0);
`endif

        // Random traffic against the behavioural model.
        do_reset();
        m_redir_left = 0;
        m_in_fence   = 1'b0;
        m_fence_age  = 0;
        m_stall_n    = 0;
        m_flush_n    = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rs1addr_d  = 5'($urandom_range(0, 3));
            rs2addr_d  = 5'($urandom_range(0, 3));
            rs1addr_e  = 5'($urandom_range(0, 3));
            rs2addr_e  = 5'($urandom_range(0, 3));
            rd_e       = 5'($urandom_range(0, 3));
            rd_m       = 5'($urandom_range(0, 3));
            rd_w       = 5'($urandom_range(0, 3));
            regwe_e    = 1'($urandom_range(0, 1));
            regwe_m    = 1'($urandom_range(0, 1));
            regwe_w    = 1'($urandom_range(0, 1));
            wb_sel_e   = 2'($urandom_range(0, 3));
            redirect_e = ($urandom_range(0, 7) == 0);
            fence_e    = ($urandom_range(0, 11) == 0);
            mem_busy   = 1'($urandom_range(0, 1));
            @(negedge clk_in);

            m_luse = regwe_e && wb_sel_e == 2'b01 && rd_e != 0 &&
                     (rd_e == rs1addr_d || rd_e == rs2addr_d);
            if (m_in_fence)            exp_ctl = 5'b11011;
            else if (m_redir_left > 0) exp_ctl = 5'b00110;
            else if (redirect_e)       exp_ctl = 5'b00110;
            else if (m_luse)           exp_ctl = 5'b11010;
            else                       exp_ctl = 5'b00000;
            chk("rand_ctl", 64'(ctl()), 64'(exp_ctl));
            chk("rand_fwd", 64'({fwd_a_sel, fwd_b_sel}),
                64'({ref_fwd(rs1addr_e), ref_fwd(rs2addr_e)}));
`ifdef HAZARD_PERF_CNT_EN
            exp_sc = 32'(m_stall_n);
            exp_fc = 32'(m_flush_n);
`else
            exp_sc = 32'd0;
            exp_fc = 32'd0;
`endif
            chk("rand_cnt", 64'({stall_cnt, flush_cnt}), 64'({exp_sc, exp_fc}));
            m_stall_n += exp_ctl[4];
            m_flush_n += exp_ctl[1];

            if (m_in_fence) begin
                if (m_fence_age >= D && !mem_busy) m_in_fence = 1'b0;
                else m_fence_age++;
            end else if (m_redir_left > 0) begin
                if (redirect_e) m_redir_left = R - 1;
                else m_redir_left--;
            end else if (redirect_e) begin
                m_redir_left = R - 1;
            end else if (fence_e) begin
                m_in_fence  = 1'b1;
                m_fence_age = 0;
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
